// File: rtl/ray_line_collector_pkg.sv
// Shared geometry, colour type and FSM encoding for the raytracing line collector.
// Both the collector and the workers import this so they agree on the buffer layout.
package ray_line_collector_pkg;

  localparam int N_WORKERS        = 10;
  localparam int JOBS_SUBDIVISION = 64;
  localparam int JOBS             = N_WORKERS * JOBS_SUBDIVISION;
  localparam int COLOR_B          = 12;
  localparam int X_B              = 10;
  localparam int LINE_Y_B         = 9;

  typedef logic [COLOR_B-1:0] color_t;

  localparam color_t BACKGROUND_COLOR = '0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_RELEASE   = 3'd4
  } state_t;

  // Index width that stays legal for a count of one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ray_line_collector_drain_index_counter.sv
// Walks the drain order: worker index w fastest, then job k, with a running screen x.
// o_last flags the final pixel of the line; the counter never steps past it.
module drain_index_counter
  import ray_line_collector_pkg::*;
#(
  parameter int N_WORKERS        = ray_line_collector_pkg::N_WORKERS,
  parameter int JOBS_SUBDIVISION = ray_line_collector_pkg::JOBS_SUBDIVISION,
  parameter int X_B              = ray_line_collector_pkg::X_B,
  parameter int W_B              = idx_width(N_WORKERS),
  parameter int K_B              = idx_width(JOBS_SUBDIVISION)
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           i_clear,
  input  logic           i_advance,
  output logic [W_B-1:0] o_w,
  output logic [K_B-1:0] o_k,
  output logic [X_B-1:0] o_x,
  output logic           o_last
);

  logic [W_B-1:0] r_w;
  logic [K_B-1:0] r_k;
  logic [X_B-1:0] r_x;

  always_ff @(posedge clk) begin
    if (!rst_ || i_clear) begin
      r_w <= '0;
      r_k <= '0;
      r_x <= '0;
    end else if (i_advance && !o_last) begin
      r_x <= r_x + 1'b1;
      if (r_w == W_B'(N_WORKERS - 1)) begin
        r_w <= '0;
        r_k <= r_k + 1'b1;
      end else begin
        r_w <= r_w + 1'b1;
      end
    end
  end

  assign o_w    = r_w;
  assign o_k    = r_k;
  assign o_x    = r_x;
  assign o_last = (r_x == X_B'(N_WORKERS * JOBS_SUBDIVISION - 1));

endmodule

// File: rtl/ray_line_collector.sv
// Starts a scan line on all workers, waits for every worker to finish, then drains the
// worker buffers in screen-x order through a registered valid/ready pixel port.
module ray_line_collector
  import ray_line_collector_pkg::*;
#(
  parameter int N_WORKERS        = ray_line_collector_pkg::N_WORKERS,
  parameter int JOBS_SUBDIVISION = ray_line_collector_pkg::JOBS_SUBDIVISION,
  parameter int COLOR_B          = ray_line_collector_pkg::COLOR_B,
  parameter int X_B              = ray_line_collector_pkg::X_B,
  parameter int LINE_Y_B         = ray_line_collector_pkg::LINE_Y_B
) (
  input  logic                                          clk,
  input  logic                                          rst_,
  input  logic                                          line_start,
  input  logic [LINE_Y_B-1:0]                           line_y,
  output logic                                          ready,
  output logic                                          line_done,
  output logic                                          worker_activate,
  input  logic [N_WORKERS-1:0]                          worker_busy,
  input  logic [N_WORKERS*JOBS_SUBDIVISION*COLOR_B-1:0] worker_buffer,
  output logic                                          wr_valid,
  input  logic                                          wr_ready,
  output logic [X_B-1:0]                                wr_x,
  output logic [LINE_Y_B-1:0]                           wr_y,
  output logic [COLOR_B-1:0]                            wr_color,
  output state_t                                        dbg_state
);

  localparam int PIX   = N_WORKERS * JOBS_SUBDIVISION;
  localparam int W_B   = idx_width(N_WORKERS);
  localparam int K_B   = idx_width(JOBS_SUBDIVISION);
  localparam int IDX_B = idx_width(PIX);

  // Pixel port handshake: a pixel transfers on a rising edge where wr_valid && wr_ready.
  // Once wr_valid is high, wr_x/wr_y/wr_color stay frozen until that transfer happens.

  state_t r_state;
  state_t w_next;

  logic [N_WORKERS-1:0] r_seen;
  logic [N_WORKERS-1:0] w_seen_now;
  logic                 r_wr_valid;
  logic [X_B-1:0]       r_wr_x;
  logic [LINE_Y_B-1:0]  r_wr_y;
  logic [COLOR_B-1:0]   r_wr_color;
  logic                 r_all_issued;

  logic                 w_load;
  logic                 w_last_hs;
  logic                 w_cnt_clear;
  logic [W_B-1:0]       w_cnt_w;
  logic [K_B-1:0]       w_cnt_k;
  logic [X_B-1:0]       w_cnt_x;
  logic                 w_cnt_last;
  logic [IDX_B-1:0]     w_pix_idx;
  logic [COLOR_B-1:0]   w_buf [PIX];

  for (genvar i = 0; i < PIX; i++) begin : g_unpack
    assign w_buf[i] = worker_buffer[i*COLOR_B +: COLOR_B];
  end

  assign w_seen_now  = r_seen | worker_busy;
  assign w_load      = (r_state == ST_DRAIN) && !r_all_issued && (!r_wr_valid || wr_ready);
  assign w_last_hs   = (r_state == ST_DRAIN) && r_all_issued && r_wr_valid && wr_ready;
  assign w_cnt_clear = (r_state != ST_DRAIN);
  assign w_pix_idx   = IDX_B'(w_cnt_w) * IDX_B'(JOBS_SUBDIVISION) + IDX_B'(w_cnt_k);

  drain_index_counter #(
    .N_WORKERS       (N_WORKERS),
    .JOBS_SUBDIVISION(JOBS_SUBDIVISION),
    .X_B             (X_B),
    .W_B             (W_B),
    .K_B             (K_B)
  ) u_idx (
    .clk      (clk),
    .rst_     (rst_),
    .i_clear  (w_cnt_clear),
    .i_advance(w_load),
    .o_w      (w_cnt_w),
    .o_k      (w_cnt_k),
    .o_x      (w_cnt_x),
    .o_last   (w_cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (line_start)          w_next = ST_ARM;
      ST_ARM:       if (&w_seen_now)         w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (worker_busy == '0)   w_next = ST_DRAIN;
      ST_DRAIN:     if (w_last_hs)           w_next = ST_RELEASE;
      ST_RELEASE:                            w_next = ST_IDLE;
      default:                               w_next = ST_IDLE;
    endcase
  end

  // Activate stays high through DRAIN so finished workers hold their buffers steady.
  always_comb begin
    ready           = 1'b0;
    line_done       = 1'b0;
    worker_activate = 1'b0;
    case (r_state)
      ST_IDLE:      ready = 1'b1;
      ST_ARM,
      ST_WAIT_DONE,
      ST_DRAIN:     worker_activate = 1'b1;
      ST_RELEASE:   line_done = 1'b1;
      default:      ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_seen       <= '0;
      r_wr_valid   <= 1'b0;
      r_wr_x       <= '0;
      r_wr_y       <= '0;
      r_wr_color   <= '0;
      r_all_issued <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && line_start) begin
        r_wr_y <= line_y;
        r_seen <= '0;
      end
      if (r_state == ST_ARM) begin
        r_seen <= w_seen_now;
      end
      if (w_load) begin
        r_wr_color   <= w_buf[w_pix_idx];
        r_wr_x       <= w_cnt_x;
        r_wr_valid   <= 1'b1;
        r_all_issued <= w_cnt_last;
      end else if (w_last_hs) begin
        r_wr_valid <= 1'b0;
      end
      if (r_state != ST_DRAIN) begin
        r_all_issued <= 1'b0;
      end
    end
  end

  assign wr_valid  = r_wr_valid;
  assign wr_x      = r_wr_x;
  assign wr_y      = r_wr_y;
  assign wr_color  = r_wr_color;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ray_line_collector.sv
// Bench for ray_line_collector: behavioural workers, random pixel sink, and a scoreboard
// fed from a screen-order model of the line (x -> worker x%N, job x/N).
module tb_ray_line_collector;
  import ray_line_collector_pkg::*;

  localparam int NW  = N_WORKERS;
  localparam int NJ  = JOBS_SUBDIVISION;
  localparam int CB  = COLOR_B;
  localparam int XB  = X_B;
  localparam int YB  = LINE_Y_B;
  localparam int PIX = NW * NJ;

  logic                  clk;
  logic                  rst_;
  logic                  line_start;
  logic [YB-1:0]         line_y;
  logic                  ready;
  logic                  line_done;
  logic                  worker_activate;
  logic [NW-1:0]         worker_busy;
  logic [NW*NJ*CB-1:0]   worker_buffer;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [XB-1:0]         wr_x;
  logic [YB-1:0]         wr_y;
  logic [CB-1:0]         wr_color;
  state_t                dbg_state;

  ray_line_collector dut (
    .clk            (clk),
    .rst_           (rst_),
    .line_start     (line_start),
    .line_y         (line_y),
    .ready          (ready),
    .line_done      (line_done),
    .worker_activate(worker_activate),
    .worker_busy    (worker_busy),
    .worker_buffer  (worker_buffer),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_x           (wr_x),
    .wr_y           (wr_y),
    .wr_color       (wr_color),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- worker + sink models ----------------
  logic [CB-1:0] buf_mem [NW][NJ];
  int m_phase [NW];
  int m_cnt   [NW];
  int m_delay [NW];
  int ready_mode = 0;
  int stall_cnt  = 0;
  bit stall_done = 1'b0;

  always @(negedge clk) begin
    for (int w = 0; w < NW; w++) begin
      if (!worker_activate) begin
        m_phase[w] = 0;
        worker_busy[w] = 1'b0;
      end else begin
        case (m_phase[w])
          0: begin worker_busy[w] = 1'b1; m_cnt[w] = m_delay[w]; m_phase[w] = 1; end
          1: if (m_cnt[w] == 0) begin worker_busy[w] = 1'b0; m_phase[w] = 2; end
             else m_cnt[w]--;
          default: worker_busy[w] = 1'b0;
        endcase
      end
    end
    if (ready_mode == 0) begin
      wr_ready = 1'b1;
    end else if (stall_cnt > 0) begin
      wr_ready = 1'b0;
      stall_cnt--;
    end else if (!stall_done && wr_valid && wr_x == XB'(100)) begin
      wr_ready   = 1'b0;
      stall_cnt  = 19;
      stall_done = 1'b1;
    end else begin
      wr_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [XB+YB+CB-1:0] exp_q[$];
  logic [CB-1:0] cap_color [PIX];
  int  cyc = 0;
  int  hs_count = 0;
  int  done_count = 0;
  int  first_t = 0;
  int  last_t = 0;
  int  busy_viol = 0;
  bit  hold_pending = 1'b0;
  logic [XB-1:0] hold_x;
  logic [CB-1:0] hold_c;
  logic [XB+YB+CB-1:0] e;

  always @(negedge clk) begin
    #1;
    cyc++;
    if (!rst_) begin
      hold_pending = 1'b0;
    end else begin
      if (wr_valid && worker_busy != '0) busy_viol++;
      if (hold_pending) chk("hold_stable", {wr_valid, wr_x, wr_color}, {1'b1, hold_x, hold_c});
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_extra_pixel", 32'(wr_x), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", 32'({wr_x, wr_y, wr_color}), 32'(e));
        end
        if (wr_x < XB'(PIX)) cap_color[wr_x] = wr_color;
        if (hs_count == 0) first_t = cyc;
        last_t = cyc;
        hs_count++;
      end
      hold_pending = wr_valid && !wr_ready;
      hold_x = wr_x;
      hold_c = wr_color;
      if (line_done) done_count++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_buf(input bit pattern);
    for (int w = 0; w < NW; w++) begin
      for (int k = 0; k < NJ; k++) begin
        buf_mem[w][k] = pattern ? {4'(w), 4'(k), 4'hA} : CB'($urandom);
        worker_buffer[(w*NJ+k)*CB +: CB] = buf_mem[w][k];
      end
    end
  endtask

  task automatic set_delays(input int extra9);
    for (int w = 0; w < NW; w++) m_delay[w] = $urandom_range(2, 10);
    m_delay[NW-1] = m_delay[NW-1] + extra9;
  endtask

  task automatic build_exp(input logic [YB-1:0] y);
    exp_q.delete();
    for (int x = 0; x < PIX; x++) exp_q.push_back({XB'(x), y, buf_mem[x % NW][x / NW]});
  endtask

  task automatic start_line(input logic [YB-1:0] y);
    hs_count   = 0;
    done_count = 0;
    build_exp(y);
    @(negedge clk);
    line_y     = y;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic finish_line();
    bit ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk); #2;
      if (line_done) ok = 1'b1;
    end
    chk("line_done_seen", 32'(ok), 32'd1);
    chk("release_activate_low", 32'(worker_activate), 32'd0);
    chk("release_not_ready", 32'(ready), 32'd0);
    @(negedge clk); #2;
    chk("ready_after_release", 32'(ready), 32'd1);
    chk("line_done_pulse_1clk", 32'(line_done), 32'd0);
    chk("handshake_count", 32'(hs_count), 32'(PIX));
    chk("line_done_count", 32'(done_count), 32'd1);
    chk("expected_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    int          x;
    logic [CB-1:0] color;
  } spot_t;
  spot_t spots [6];

  initial begin
    bit found;
    rst_          = 1'b0;
    line_start    = 1'b0;
    line_y        = '0;
    wr_ready      = 1'b1;
    worker_busy   = '0;
    worker_buffer = '0;
    set_delays(0);

    // 1: reset state
    repeat (2) @(negedge clk);
    #2;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_activate", 32'(worker_activate), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_line_done", 32'(line_done), 32'd0);
    chk("rst_wr_x_y_color", 32'({wr_x, wr_y, wr_color}), 32'd0);
    @(negedge clk);
    rst_ = 1'b1;

    // 2: normal line with a recognisable colour pattern
    spots[0] = '{0,   12'h00A};
    spots[1] = '{9,   12'h90A};
    spots[2] = '{10,  12'h01A};
    spots[3] = '{23,  12'h32A};
    spots[4] = '{155, 12'h5FA};
    spots[5] = '{639, 12'h9FA};
    ready_mode = 0;
    fill_buf(1'b1);
    set_delays(0);
    start_line(YB'(37));
    finish_line();
    chk("burst_consecutive", 32'(last_t - first_t), 32'(PIX - 1));
    for (int i = 0; i < 6; i++) chk($sformatf("spot_x%0d", spots[i].x), 32'(cap_color[spots[i].x]), 32'(spots[i].color));

    // 3 + 6: worker 9 finishes late; a line_start during WAIT_DONE must be ignored
    fill_buf(1'b0);
    set_delays(200);
    busy_viol = 0;
    start_line(YB'(200));
    repeat (40) @(negedge clk);
    #2;
    chk("in_wait_done", 32'(dbg_state), 32'(ST_WAIT_DONE));
    chk("no_valid_while_busy", 32'(wr_valid), 32'd0);
    chk("not_ready_mid_line", 32'(ready), 32'd0);
    @(negedge clk);
    line_y = YB'(99);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    finish_line();
    chk("busy_vs_valid_violations", 32'(busy_viol), 32'd0);

    // 4: random backpressure with a 20-cycle stall on x=100
    fill_buf(1'b0);
    set_delays(0);
    ready_mode = 1;
    stall_done = 1'b0;
    start_line(YB'(5));
    finish_line();
    chk("stall_happened", 32'(stall_done), 32'd1);
    ready_mode = 0;

    // 5: reset in the middle of DRAIN, then a clean full line
    fill_buf(1'b0);
    set_delays(0);
    start_line(YB'(300));
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk); #2;
      if (wr_valid && wr_x == XB'(300)) found = 1'b1;
    end
    chk("reached_x300", 32'(found), 32'd1);
    @(negedge clk);
    rst_ = 1'b0;
    @(negedge clk); #2;
    chk("midrst_wr_valid", 32'(wr_valid), 32'd0);
    chk("midrst_activate", 32'(worker_activate), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_line_done", 32'(line_done), 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    exp_q.delete();
    fill_buf(1'b0);
    start_line(YB'(77));
    finish_line();
    chk("busy_vs_valid_violations_end", 32'(busy_viol), 32'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
